// File: rtl/sdram_frame_writer_pkg.sv
// Shared constants and state encoding for the SDRAM frame writer.
// The display reader uses the same address-field layout.
package sdram_frame_writer_pkg;

  localparam int FRAME_MSB = 24;
  localparam int LINE_LSB  = 9;
  localparam int WORD_LSB  = 0;

  localparam int LINES_DEF = 1024;
  localparam int WORDS_DEF = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_U,
    ST_LAT_U,
    ST_GET_L,
    ST_LAT_L,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [24:0] wr_addr(
    input logic [5:0] f,
    input logic [9:0] l,
    input logic [8:0] w
  );
    logic [24:0] a;
    a = '0;
    a[FRAME_MSB -: 6] = f;
    a[LINE_LSB +: 10] = l;
    a[WORD_LSB +: 9]  = w;
    return a;
  endfunction

endpackage

// File: rtl/sdram_frame_writer_if.sv
// Byte-FIFO read port and SDRAM single-word write port.
// master = frame writer, slave = FIFO/controller side.
interface sdram_frame_writer_if;

  logic        iFIFO_EMPTY;
  logic [7:0]  iFIFO_DATA;
  logic        oFIFO_RDREQ;
  logic        iWAIT_REQUEST;
  logic        oWR_EN;
  logic [24:0] oWR_ADDR;
  logic [15:0] oWR_DATA;

  modport master (
    input  iFIFO_EMPTY, iFIFO_DATA, iWAIT_REQUEST,
    output oFIFO_RDREQ, oWR_EN, oWR_ADDR, oWR_DATA
  );

  modport slave (
    output iFIFO_EMPTY, iFIFO_DATA, iWAIT_REQUEST,
    input  oFIFO_RDREQ, oWR_EN, oWR_ADDR, oWR_DATA
  );

endinterface

// File: rtl/sdram_frame_writer_packer.sv
// Byte-pair packer: FIFO read requests in the GET states and
// capture of the two bytes (first into [15:8]) in the LAT states.
module byte_pair_packer
  import sdram_frame_writer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  state_t      state_i,
  input  logic        empty_i,
  input  logic [7:0]  q_i,
  output logic        rdreq_o,
  output logic [15:0] data_o
);

  logic [15:0] data_q;

  assign rdreq_o = (state_i == ST_GET_U || state_i == ST_GET_L)
                   && !empty_i;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (state_i == ST_LAT_U) begin
      data_q[15:8] <= q_i;
    end else if (state_i == ST_LAT_L) begin
      data_q[7:0] <= q_i;
    end
  end

endmodule

// File: rtl/sdram_frame_writer.sv
// Fills one SDRAM frame slot from a byte FIFO, two bytes per word,
// using the display reader's {frame, line, word} address map.
module sdram_frame_writer
  import sdram_frame_writer_pkg::*;
#(
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_DEF
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic [5:0]           iFRAME_ID,
  input  logic                 iABORT,
  sdram_frame_writer_if.master bus,
  output logic                 oBUSY,
  output logic                 oDONE,
  output logic [9:0]           oLINE_ID
);

  localparam logic [8:0] WORD_LAST = 9'(WORDS_PER_LINE - 1);
  localparam logic [9:0] LINE_LAST = 10'(LINES - 1);

  state_t      state_q;
  logic [5:0]  frame_q;
  logic [9:0]  line_q;
  logic [8:0]  word_q;
  logic        wr_en_q;
  logic        busy_q;
  logic        done_q;
  logic        last_word;
  logic        last_line;

  assign last_word = word_q == WORD_LAST;
  assign last_line = line_q == LINE_LAST;

  byte_pair_packer u_packer (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .state_i (state_q),
    .empty_i (bus.iFIFO_EMPTY),
    .q_i     (bus.iFIFO_DATA),
    .rdreq_o (bus.oFIFO_RDREQ),
    .data_o  (bus.oWR_DATA)
  );

  assign bus.oWR_EN   = wr_en_q;
  assign bus.oWR_ADDR = wr_addr(frame_q, line_q, word_q);
  assign oBUSY        = busy_q;
  assign oDONE        = done_q;
  assign oLINE_ID     = line_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      line_q  <= '0;
      word_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (iSTART && !iABORT) begin
            frame_q <= iFRAME_ID;
            line_q  <= '0;
            word_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_GET_U;
          end
        end
        ST_GET_U, ST_GET_L: begin
          if (iABORT) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!bus.iFIFO_EMPTY) begin
            state_q <= (state_q == ST_GET_U) ? ST_LAT_U : ST_LAT_L;
          end
        end
        ST_LAT_U: begin
          if (iABORT) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_GET_L;
          end
        end
        ST_LAT_L: begin
          if (iABORT) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wr_en_q <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // abort only takes effect once the pending write is accepted
          if (!bus.iWAIT_REQUEST) begin
            wr_en_q <= 1'b0;
            if (last_word && last_line) begin
              if (iABORT) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end else begin
              if (last_word) begin
                word_q <= '0;
                line_q <= line_q + 10'd1;
              end else begin
                word_q <= word_q + 9'd1;
              end
              if (iABORT) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_GET_U;
              end
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
